// File: rtl/alu_seq.sv
// Purpose: sequences 16/32-bit operations through a 16-bit combinational ALU and holds result/flags.
// Latency: START accepted in IDLE at cycle k; DONE at k+2 (single word) or k+3 (double word).
// Backpressure: none; START is ignored (not queued) while BUSY, so callers wait for BUSY low.
//
// Ports:
//   CLK, RST_N        clock and synchronous active-low reset
//   START, OP, USE_CF operation request; OP[2] = double word, OP[1:0] = ALU function
//   XA, XB            32-bit operands, latched on acceptance
//   BUSY, DONE        status; DONE pulses for one cycle when RESULT/CF/ZF were just updated
//   RESULT, CF, ZF    last completed result and flags
//   ALU_A/B/CIN/FUNC  operand half driven to the external ALU (zero outside LO/HI)
//   ALU_OUT, ALU_COUT combinational ALU response, sampled in the same cycle
module alu_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic        USE_CF,
  input  logic [31:0] XA,
  input  logic [31:0] XB,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic        CF,
  output logic        ZF,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic        ALU_CIN,
  output logic [1:0]  ALU_FUNC,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_COUT
);

  localparam logic [1:0] FUNC_ADD = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Operation registers, captured once at acceptance.
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  func_q;
  logic        dbl_q;
  logic        cin_q;

  // Low-half partial result and its carry, used by the high half.
  logic [15:0] low_tmp;
  logic        c_tmp;

  // Architected result and flags.
  logic [31:0] result_q;
  logic        cf_q;
  logic        zf_q;

  // Values written into result/flags on the edge into FIN.
  logic        fin_load;
  logic [31:0] fin_result;
  logic        fin_cf;
  logic        fin_zf;

  logic        accept;

  assign accept = (state == S_IDLE) && START;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, ALU drive and FIN-entry result selection
  always_comb begin
    state_nxt  = state;
    ALU_A      = 16'h0000;
    ALU_B      = 16'h0000;
    ALU_CIN    = 1'b0;
    ALU_FUNC   = 2'b00;
    fin_load   = 1'b0;
    fin_result = 32'h0000_0000;
    fin_cf     = 1'b0;
    fin_zf     = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = S_LO;
        end
      end

      S_LO: begin
        ALU_A    = a_q[15:0];
        ALU_B    = b_q[15:0];
        ALU_FUNC = func_q;
        ALU_CIN  = cin_q;
        if (dbl_q) begin
          state_nxt = S_HI;
        end else begin
          state_nxt  = S_FIN;
          fin_load   = 1'b1;
          fin_result = {16'h0000, ALU_OUT};
          // ALU_COUT carries no meaning for logic functions.
          fin_cf     = (func_q == FUNC_ADD) && ALU_COUT;
          fin_zf     = (ALU_OUT == 16'h0000);
        end
      end

      S_HI: begin
        ALU_A      = a_q[31:16];
        ALU_B      = b_q[31:16];
        ALU_FUNC   = func_q;
        // Carry chain from the low half only for adds.
        ALU_CIN    = (func_q == FUNC_ADD) && c_tmp;
        state_nxt  = S_FIN;
        fin_load   = 1'b1;
        fin_result = {ALU_OUT, low_tmp};
        fin_cf     = (func_q == FUNC_ADD) && ALU_COUT;
        fin_zf     = (ALU_OUT == 16'h0000) && (low_tmp == 16'h0000);
      end

      S_FIN: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operation capture, low-half staging and result/flag registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
      func_q   <= 2'b00;
      dbl_q    <= 1'b0;
      cin_q    <= 1'b0;
      low_tmp  <= 16'h0000;
      c_tmp    <= 1'b0;
      result_q <= 32'h0000_0000;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= XA;
        b_q    <= XB;
        func_q <= OP[1:0];
        dbl_q  <= OP[2];
        // Stored CF feeds the add only on request (add-with-carry).
        cin_q  <= (OP[1:0] == FUNC_ADD) && USE_CF && cf_q;
      end
      if (state == S_LO) begin
        low_tmp <= ALU_OUT;
        c_tmp   <= ALU_COUT;
      end
      if (fin_load) begin
        result_q <= fin_result;
        cf_q     <= fin_cf;
        zf_q     <= fin_zf;
      end
    end
  end

  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_FIN);
  assign RESULT = result_q;
  assign CF     = cf_q;
  assign ZF     = zf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: behavioural 84CP ALU on the ALU_* ports, scoreboard of
// expected results filled at issue time and drained by a DONE monitor.
module tb_alu_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'b000;
  logic        USE_CF = 1'b0;
  logic [31:0] XA = 32'h0;
  logic [31:0] XB = 32'h0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic        CF;
  logic        ZF;
  logic [15:0] ALU_A;
  logic [15:0] ALU_B;
  logic        ALU_CIN;
  logic [1:0]  ALU_FUNC;
  logic [15:0] ALU_OUT;
  logic        ALU_COUT;

  alu_seq dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .USE_CF(USE_CF),
    .XA(XA), .XB(XB), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .CF(CF), .ZF(ZF),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN), .ALU_FUNC(ALU_FUNC),
    .ALU_OUT(ALU_OUT), .ALU_COUT(ALU_COUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural 16-bit adder/logic unit.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum  = {1'b0, ALU_A} + {1'b0, ALU_B} + {16'h0000, ALU_CIN};
    ALU_OUT  = 16'h0000;
    ALU_COUT = 1'b0;
    case (ALU_FUNC)
      2'b00: begin ALU_OUT = alu_sum[15:0]; ALU_COUT = alu_sum[16]; end
      2'b01: ALU_OUT = ALU_A & ~ALU_B;
      2'b10: ALU_OUT = ALU_A | ALU_B;
      default: begin ALU_OUT = ~ALU_B; ALU_COUT = 1'b1; end
    endcase
  end

  typedef struct {
    logic [31:0] res;
    logic        cf;
    logic        zf;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic ref_cf = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-operand arithmetic, no half splitting.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] xa,
                                 input logic [31:0] xb, input logic cin, input int dcyc);
    exp_t        e;
    logic [31:0] mask;
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    mask = op[2] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    s = 33'h0;
    c = 1'b0;
    case (op[1:0])
      2'b00: begin
        s = {1'b0, xa & mask} + {1'b0, xb & mask} + {32'h0, cin};
        r = s[31:0] & mask;
        c = op[2] ? s[32] : s[16];
      end
      2'b01:   r = xa & ~xb & mask;
      2'b10:   r = (xa | xb) & mask;
      default: r = ~xb & mask;
    endcase
    e.res      = r;
    e.cf       = c;
    e.zf       = (r == 32'h0);
    e.done_cyc = dcyc;
    return e;
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: DONE=1 at cycle %0d, expected no DONE", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", RESULT, mon_e.res);
        check("cf", {31'h0, CF}, {31'h0, mon_e.cf});
        check("zf", {31'h0, ZF}, {31'h0, mon_e.zf});
        check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
        check("busy_in_fin", {31'h0, BUSY}, 32'h1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: BUSY=%b after %0d cycles, expected 0", BUSY, n);
    end
  endtask

  // Drives a request at a negedge in IDLE; returns #1 after the accepting edge
  // (or one cycle later when hold keeps a stray START up during LO).
  task automatic issue(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       input logic ucf, input bit hold);
    logic cin;
    exp_t e;
    wait_idle();
    cin = (op[1:0] == 2'b00 && ucf) ? ref_cf : 1'b0;
    e = model(op, xa, xb, cin, cyc + (op[2] ? 3 : 2));
    sb.push_back(e);
    ref_cf = e.cf;
    OP = op; XA = xa; XB = xb; USE_CF = ucf; START = 1'b1;
    @(posedge CLK); #1;
    if (hold) begin
      OP = 3'($urandom); XA = $urandom; XB = $urandom; USE_CF = 1'($urandom);
      @(posedge CLK); #1;
    end
    START = 1'b0;
    OP = 3'($urandom); XA = $urandom; XB = $urandom; USE_CF = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset held for two edges.
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    check("rst_done", {31'h0, DONE}, 32'h0);
    check("rst_result", RESULT, 32'h0);
    check("rst_flags", {30'h0, CF, ZF}, 32'h0);
    check("rst_alu", {ALU_A, ALU_B[12:0], ALU_CIN, ALU_FUNC}, 32'h0);
    check("rst_alu_b", {16'h0, ALU_B}, 32'h0);

    // START while in reset is not accepted.
    @(negedge CLK);
    RST_N = 1'b0; START = 1'b1; OP = 3'b100; XA = 32'h1; XB = 32'h1;
    @(posedge CLK); #1;
    START = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
    check("start_in_reset_busy", {31'h0, BUSY}, 32'h0);
    ref_cf = 1'b0;

    // Single-word add with wrap.
    issue(3'b000, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_idle();
    check("sadd_result", RESULT, 32'h0);
    check("sadd_cf_zf", {30'h0, CF, ZF}, 32'h3);

    // Add-with-carry from stored CF.
    issue(3'b000, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
    @(negedge CLK);
    check("adc_cin_lo", {31'h0, ALU_CIN}, 32'h1);
    wait_idle();
    check("adc_result", RESULT, 32'h4);
    check("adc_cf", {31'h0, CF}, 32'h0);

    // USE_CF ignored for logic functions.
    issue(3'b000, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(3'b010, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
    @(negedge CLK);
    check("or_cin_lo", {31'h0, ALU_CIN}, 32'h0);
    check("or_func_lo", {30'h0, ALU_FUNC}, 32'h2);

    // Double-word add with carry chain into the high half.
    issue(3'b100, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge CLK);
    check("dbl_cin_lo", {31'h0, ALU_CIN}, 32'h0);
    check("dbl_a_lo", {16'h0, ALU_A}, 32'h0000_FFFF);
    @(negedge CLK);
    check("dbl_cin_hi", {31'h0, ALU_CIN}, 32'h1);
    check("dbl_a_hi", {16'h0, ALU_A}, 32'h0);
    wait_idle();
    check("dbl_result", RESULT, 32'h0001_0000);
    check("dbl_cf_zf", {30'h0, CF, ZF}, 32'h0);

    // ~B with the ALU reporting carry: CF must stay clear.
    issue(3'b111, $urandom, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle();
    check("not_result", RESULT, 32'h0);
    check("not_cf_zf", {30'h0, CF, ZF}, 32'h1);
    check("idle_alu_zero", {ALU_A, ALU_B[12:0], ALU_CIN, ALU_FUNC}, 32'h0);

    // Randomized back-to-back traffic, with occasional stray START during LO.
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
      issue(rop, ra, rb, 1'($urandom), 1'($urandom));
    end
    wait_idle();

    // Abort: double add, stray START in LO, reset in HI.
    issue(3'b000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    wait_idle();
    check("pre_abort_result", RESULT, 32'h2);
    issue(3'b100, 32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge CLK);
    START = 1'b1; OP = 3'b000; XA = 32'h7; XB = 32'h9;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check("abort_busy_hi", {31'h0, BUSY}, 32'h1);
    sb.delete();
    RST_N = 1'b0;
    @(posedge CLK); #1;
    check("abort_busy", {31'h0, BUSY}, 32'h0);
    check("abort_done", {31'h0, DONE}, 32'h0);
    check("abort_result", RESULT, 32'h0);
    check("abort_flags", {30'h0, CF, ZF}, 32'h0);
    RST_N = 1'b1;
    ref_cf = 1'b0;
    issue(3'b000, 32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0);
    wait_idle();
    check("post_abort_result", RESULT, 32'hB);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Operand sequencer and result/flag register for the 84CP 16-bit adder/logic unit. It accepts a single-word (16-bit) or double-word (32-bit) operation and drives the combinational ALU's A, B, C_IN and FUNC inputs one 16-bit half per cycle. For double-word adds it chains the ALU's C_OUT into the high half. It captures the ALU's OUT/C_OUT into a 32-bit result register with carry and zero flags, and holds them for the datapath.

## Interface
- No parameters; the ALU slice width is fixed at 16 bits and the operand width at 32 bits.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- START  in  1  operation request; sampled only in IDLE.
- OP  in  3  OP[2] = DBL (1 = 32-bit); OP[1:0] = FUNC (00 add, 01 A&~B, 10 A|B, 11 ~B).
- USE_CF  in  1  when 1 and FUNC = 00, the low-half carry-in is the stored CF; otherwise 0.
- XA  in  32  operand A; only XA[15:0] is used when DBL = 0.
- XB  in  32  operand B; only XB[15:0] is used when DBL = 0.
- BUSY  out  1  high whenever the state is not IDLE.
- DONE  out  1  one-cycle pulse; RESULT/CF/ZF were updated on the edge that entered this cycle.
- RESULT  out  32  last completed result; bits [31:16] are 0 for single-word ops.
- CF  out  1  carry flag.
- ZF  out  1  zero flag.
- ALU_A  out  16  operand half to the ALU.
- ALU_B  out  16  operand half to the ALU.
- ALU_CIN  out  1  carry-in to the ALU.
- ALU_FUNC  out  2  function select to the ALU.
- ALU_OUT  in  16  ALU result.
- ALU_COUT  in  1  ALU carry out.

## Operation
- States:
  - IDLE → LO on START = 1.
  - LO → HI if DBL = 1.
  - LO → FIN if DBL = 0.
  - HI → FIN.
  - FIN → IDLE.
- IDLE with START = 1: latch XA, XB, FUNC and DBL into internal registers. Latch the carry-in as (FUNC == 00 && USE_CF) ? CF : 0.
- LO: drive the following, and capture ALU_OUT into low_tmp and ALU_COUT into c_tmp:
  - ALU_A = a[15:0]
  - ALU_B = b[15:0]
  - ALU_FUNC = func
  - ALU_CIN = latched carry-in
- HI: drive the following:
  - ALU_A = a[31:16]
  - ALU_B = b[31:16]
  - ALU_FUNC = func
  - ALU_CIN = (func == 00) ? c_tmp : 0
- Register update on the edge into FIN:
  - RESULT = {hi, low_tmp} for double-word, {16'h0, ALU_OUT} for single-word (hi is ALU_OUT in HI).
  - CF = the last ALU_COUT when func == 00; CF = 0 for logic ops, regardless of ALU_COUT, because ALU_COUT is meaningless for logic ops (FUNC 11 reports 1).
  - ZF = 1 iff all produced result bits are 0 (16 or 32 bits).
- FIN: DONE = 1 and BUSY = 1.
- Outside LO/HI: ALU_A, ALU_B, ALU_FUNC and ALU_CIN are all 0.
- RESULT, CF and ZF change only on entry to FIN or on reset; otherwise they hold.
- START while BUSY (LO/HI/FIN): ignored, not queued. XA/XB/OP/USE_CF changes after acceptance have no effect.

## Timing
- START is sampled high in IDLE in cycle k.
  - Single-word: LO in k+1, DONE = 1 in k+2, IDLE in k+3. The earliest next acceptance is cycle k+3.
  - Double-word: LO in k+1, HI in k+2, DONE = 1 in k+3, IDLE in k+4.
- The ALU is purely combinational; ALU_OUT/ALU_COUT are sampled at the end of the same cycle in which ALU_* are driven.
- Reset (RST_N = 0 at an edge) forces the following on that edge, with priority over all other events including START:
  - state = IDLE
  - BUSY = 0, DONE = 0
  - RESULT = 0, CF = 0, ZF = 0
  - ALU_* = 0
  - internal registers = 0
- Reset mid-operation aborts without a DONE pulse, and the prior RESULT is lost.
- Wrap-around: a 32-bit add overflow sets CF = 1 with RESULT = low 32 bits. A 16-bit overflow sets CF = 1 with RESULT[31:16] = 0.

## Test plan
(Bench connects a behavioural model of the 84CP adder/logic unit to the ALU_* ports.)
- Reset: hold RST_N = 0 for 2 cycles, then release → BUSY = 0, DONE = 0, RESULT = 0, CF = 0, ZF = 0, ALU_A/B/CIN/FUNC = 0. START with RST_N = 0 → still IDLE.
- Single add: OP = 000, XA = 0xFFFF, XB = 0x0001, USE_CF = 0 → DONE exactly at k+2, RESULT = 0x00000000, CF = 1, ZF = 1.
- Double add carry chain: OP = 100, XA = 0x0000FFFF, XB = 0x00000001 → ALU_CIN = 0 in LO and 1 in HI, DONE at k+3, RESULT = 0x00010000, CF = 0, ZF = 0.
- ADC from stored flag: after the single add above (CF = 1), OP = 000, XA = 0x0001, XB = 0x0002, USE_CF = 1 → ALU_CIN = 1 in LO, RESULT = 0x00000004, CF = 0. Repeat with OP = 010 and USE_CF = 1 → ALU_CIN = 0.
- Logic op flag masking: OP = 111, XB = 0xFFFFFFFF (model returns ALU_COUT = 1) → RESULT = 0x00000000, ZF = 1, CF = 0.
- Abort and busy: START a double add, pulse START again in LO (ignored, no second DONE), then drop RST_N in HI → no DONE, BUSY = 0 and RESULT = 0 the next cycle, and a new START is accepted immediately after RST_N returns high.
